// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp
//   SPI responder standing in for an 8-channel, 12-bit A2D converter.
//   Each 16-bit transaction shifts out, MSB first, {4'h0, sample} of the
//   channel latched by the previous transaction. At the same time it captures
//   a new channel command from MOSI.
//
// Parameters
//   SYNC_STAGES  flops per SCLK/SS_n/MOSI synchronizer (>= 2)
//
// Ports
//   clk        system clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   SS_n       active-low slave select from the master
//   SCLK       serial clock from the master (idles high)
//   MOSI       command data, MSB first
//   MISO       result data, MSB first, 0 while SS_n is high
//   ch_data    channel n sample = ch_data[12n+11:12n]
//   cmd_rdy    one-clk pulse when a complete 16-bit command is accepted
//   last_chnl  channel latched by the most recent accepted command
//   err        sticky protocol error (only with A2D_RESP_CHK_EN defined)
//   state_dbg  current FSM state (0 = IDLE, 1 = ACTIVE)
//
// Handshake: there is no valid/ready pair here. A transaction is framed by
// SS_n low. Data moves on synchronized SCLK edges: the master samples MISO
// on rise and this block shifts MISO on fall. A completed command is
// signalled by cmd_rdy, which is a pulse that has no back-pressure.
//
// Optional build macro: A2D_RESP_CHK_EN enables the protocol checker
// that drives err.
module a2d_spi_resp #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [95:0] ch_data,
  output logic        cmd_rdy,
  output logic [2:0]  last_chnl,
  output logic        err,
  output logic        state_dbg
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic        sclk_prev;
  logic        sclk_s, ss_s, mosi_s;
  logic        sclk_rise, sclk_fall;

  logic [15:0] tx_shft, rx_shft;
  logic [4:0]  bit_cnt;
  logic        first_fall;

  logic        load, rise_en, fall_en, done;
  logic        cmd_ok;
  logic [6:0]  sel_base;
  logic [11:0] sel_sample;

  // Synchronizers. SCLK and SS_n reset to their idle (high) level so that
  // no edge is seen at reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // SS_n rising ends the transaction and masks any SCLK edge in that clk.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    rise_en   = 1'b0;
    fall_en   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (!ss_s) begin
          state_nxt = ACTIVE;
          load      = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_s) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end else begin
          rise_en = sclk_rise;
          fall_en = sclk_fall;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign state_dbg  = state;
  assign sel_base   = {4'd0, last_chnl} * 7'd12;
  assign sel_sample = ch_data[sel_base +: 12];
  assign cmd_ok     = done && (bit_cnt == 5'd16);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft    <= '0;
      rx_shft    <= '0;
      bit_cnt    <= '0;
      first_fall <= 1'b0;
      last_chnl  <= '0;
      cmd_rdy    <= 1'b0;
    end else begin
      cmd_rdy <= cmd_ok;
      if (cmd_ok) last_chnl <= rx_shft[13:11];
      if (load) begin
        // Sample is frozen here, so later ch_data changes are not seen.
        tx_shft    <= {4'h0, sel_sample};
        bit_cnt    <= '0;
        first_fall <= 1'b1;
      end
      if (rise_en) begin
        rx_shft <= {rx_shft[14:0], mosi_s};
        if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
      end
      if (fall_en) begin
        // The first fall precedes the first sample, and the MSB is already out.
        if (first_fall) first_fall <= 1'b0;
        else            tx_shft    <= {tx_shft[14:0], 1'b0};
      end
    end
  end

  assign MISO = ~SS_n & tx_shft[15];

`ifdef A2D_RESP_CHK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (done && ((bit_cnt != 5'd16) || (rx_shft[15:14] != 2'b00) ||
                      (rx_shft[10:0] != 11'd0)))
      err_q <= 1'b1;
  end
  assign err = err_q;
`else
  logic unused_rsvd;
  assign unused_rsvd = ^{rx_shft[15:14], rx_shft[10:0]};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_a2d_spi_resp.sv
module tb_a2d_spi_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n, SCLK, MOSI;
  logic        MISO;
  logic [95:0] ch_data;
  logic        cmd_rdy;
  logic [2:0]  last_chnl;
  logic        err;
  logic        state_dbg;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

`ifdef A2D_RESP_CHK_EN
  localparam logic ERR_PARTIAL = 1'b1;
`else
  localparam logic ERR_PARTIAL = 1'b0;
`endif

  // Clock / reset
  always #5 clk = ~clk;

  a2d_spi_resp #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .ch_data(ch_data), .cmd_rdy(cmd_rdy),
    .last_chnl(last_chnl), .err(err), .state_dbg(state_dbg)
  );

  // Driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int n, input logic [11:0] v);
    ch_data[12*n +: 12] = v;
  endtask

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_txn();
    SS_n = 1'b0;
    wait_clks(8);
  endtask

  // Drives nbits of cmd (MSB first) and samples MISO just before each rise.
  // At bit index chg_at, channel 3 is overwritten with chg_val.
  task automatic send_bits(input logic [15:0] cmd, input int nbits,
                           input int chg_at, input logic [11:0] chg_val,
                           output logic [15:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      if (i == chg_at) set_ch(3, chg_val);
      wait_clks(8);
      rx = {rx[14:0], MISO};
      SCLK = 1'b1;
      wait_clks(8);
    end
  endtask

  // Raises SS_n and counts cmd_rdy pulses over a bounded window.
  task automatic end_txn(output int rdy_cnt);
    SS_n = 1'b1;
    MOSI = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cmd_rdy) rdy_cnt++;
    end
    wait_clks(2);
  endtask

  task automatic full_txn(input logic [15:0] cmd, input int chg_at,
                          input logic [11:0] chg_val,
                          output logic [15:0] rx, output int rdy_cnt);
    start_txn();
    send_bits(cmd, 16, chg_at, chg_val, rx);
    end_txn(rdy_cnt);
  endtask

  // Directed sequence with hand-computed expectations
  logic [15:0] rx;
  int          rdy;

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    ch_data = '0;
    set_ch(0, 12'hABC);
    set_ch(2, 12'h777);
    set_ch(3, 12'h123);
    set_ch(7, 12'h9E1);
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(4);

    check("rst_miso", {15'd0, MISO}, 16'h0000);
    check("rst_last", {13'd0, last_chnl}, 16'h0000);
    check("rst_rdy", {15'd0, cmd_rdy}, 16'h0000);
    check("rst_err", {15'd0, err}, 16'h0000);
    check("rst_state", {15'd0, state_dbg}, 16'h0000);

    // First transaction returns channel 0 and commands channel 3
    full_txn(16'h1800, 99, 12'h000, rx, rdy);
    check("t1_rx", rx, 16'h0ABC);
    check("t1_rdy", rdy[15:0], 16'd1);
    check("t1_last", {13'd0, last_chnl}, 16'h0003);
    check("t1_err", {15'd0, err}, 16'h0000);

    // Returns channel 3, commands channel 0
    set_ch(3, 12'h5A5);
    full_txn(16'h0000, 99, 12'h000, rx, rdy);
    check("t2_rx", rx, 16'h05A5);
    check("t2_rdy", rdy[15:0], 16'd1);
    check("t2_last", {13'd0, last_chnl}, 16'h0000);

    // Re-select channel 3
    full_txn(16'h1800, 99, 12'h000, rx, rdy);
    check("t3a_rx", rx, 16'h0ABC);
    check("t3a_last", {13'd0, last_chnl}, 16'h0003);

    // Channel 3 changes mid-transaction; the sample frozen at SS_n fall is returned
    set_ch(3, 12'h123);
    start_txn();
    check("t3_state_active", {15'd0, state_dbg}, 16'h0001);
    send_bits(16'h1000, 16, 6, 12'hFFF, rx);
    end_txn(rdy);
    check("t3_rx_frozen", rx, 16'h0123);
    check("t3_last", {13'd0, last_chnl}, 16'h0002);
    check("t3_err", {15'd0, err}, 16'h0000);

    // Partial transaction: 9 rises, so the command is discarded
    start_txn();
    send_bits(16'h3800, 9, 99, 12'h000, rx);
    end_txn(rdy);
    check("t4_rdy", rdy[15:0], 16'd0);
    check("t4_last", {13'd0, last_chnl}, 16'h0002);
    check("t4_err", {15'd0, err}, {15'd0, ERR_PARTIAL});

    // Reserved bits set: the channel still updates
    full_txn(16'hC800, 99, 12'h000, rx, rdy);
    check("t5_rx", rx, 16'h0777);
    check("t5_rdy", rdy[15:0], 16'd1);
    check("t5_last", {13'd0, last_chnl}, 16'h0001);
    check("t5_err", {15'd0, err}, {15'd0, ERR_PARTIAL});

    // Reset in the middle of a command
    start_txn();
    send_bits(16'h3800, 8, 99, 12'h000, rx);
    rst_n = 1'b0;
    wait_clks(1);
    check("t6_rst_miso", {15'd0, MISO}, 16'h0000);
    check("t6_rst_last", {13'd0, last_chnl}, 16'h0000);
    check("t6_rst_err", {15'd0, err}, 16'h0000);
    SS_n = 1'b1; MOSI = 1'b0;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(6);

    full_txn(16'h3800, 99, 12'h000, rx, rdy);
    check("t6_rx", rx, 16'h0ABC);
    check("t6_rdy", rdy[15:0], 16'd1);
    check("t6_last", {13'd0, last_chnl}, 16'h0007);

    full_txn(16'h0000, 99, 12'h000, rx, rdy);
    check("t7_rx", rx, 16'h09E1);
    check("t7_rdy", rdy[15:0], 16'd1);
    check("t7_last", {13'd0, last_chnl}, 16'h0000);
    check("t7_err", {15'd0, err}, 16'h0000);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/a2d_spi_resp.md
# a2d_spi_resp

- Synthesizable SPI responder that models the 8-channel, 12-bit A2D converter seen by the A2D interface's SPI master.
- Used in testbenches and FPGA self-test builds in place of the real converter.
- Each 16-bit transaction returns, MSB-first on MISO, the 12-bit sample of the channel latched by the previous transaction, and captures a new channel command from MOSI.
- Sits on the same SS_n/SCLK/MOSI/MISO wires as the master; sample values come from a parallel input bus.

## Interface
- SYNC_STAGES, 2, flops in each of the SCLK/SS_n/MOSI synchronizers (minimum 2).
- clk  input  1  system clock; all state on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- SS_n  input  1  active-low slave select from the master.
- SCLK  input  1  serial clock from the master; idles high; slower than clk/8.
- MOSI  input  1  command data, MSB first.
- MISO  output  1  result data, MSB first; equals ~SS_n & tx_shft[15]; forced to 0 while SS_n is high.
- ch_data  input  96  channel n sample = ch_data[12n+11:12n], n = 0..7.
- cmd_rdy  output  1  one-clk pulse when a complete 16-bit command is accepted.
- last_chnl  output  3  channel latched by the most recent accepted command.
- err  output  1  sticky protocol error flag; tied 0 unless the checker is compiled in.

## Operation
- Synchronizers:
  - SCLK, SS_n and MOSI each pass through SYNC_STAGES flops.
  - One extra SCLK flop provides edge detect: rise = sync & ~prev, fall = ~sync & prev.
  - Sync flops reset high for SCLK and SS_n, low for MOSI.
- States:
  - IDLE: waiting for SS_n low.
  - ACTIVE: transaction in progress.
- IDLE -> ACTIVE on synchronized SS_n low. In that same clk:
  - tx_shft <= {4'h0, ch_data[last_chnl]}.
  - bit_cnt <= 0.
  - first_fall <= 1.
- ACTIVE, SCLK rise:
  - rx_shft <= {rx_shft[14:0], MOSI_sync}.
  - bit_cnt increments, saturating at 31 (5 bits).
- ACTIVE, SCLK fall:
  - If first_fall, clear first_fall only (MSB already on MISO).
  - Otherwise tx_shft <= {tx_shft[14:0], 1'b0}.
- ACTIVE -> IDLE on synchronized SS_n high:
  - If bit_cnt == 16: last_chnl <= rx_shft[13:11] and cmd_rdy pulses for one clk.
  - Otherwise the command is discarded and last_chnl is unchanged.
- Command format: bits [15:14] and [10:0] are reserved 0; channel is [13:11].
- Result format: {4'b0000, 12-bit sample}. The sample is taken when SS_n falls; changes to ch_data mid-transaction are not seen.
- Simultaneous events: a synchronized SS_n rise in the same clk as a detected SCLK edge takes priority and the edge is ignored.
- SCLK edges while in IDLE are ignored.
- Reset values: state IDLE, tx_shft 0, rx_shft 0, bit_cnt 0, first_fall 0, last_chnl 0, cmd_rdy 0, err 0, MISO 0.
- Reset mid-transaction:
  - All state clears immediately.
  - The partial command is lost.
  - The next SS_n fall starts a fresh transaction returning channel 0.

## Timing
- SCLK/SS_n edge detect latency: SYNC_STAGES+1 clks from the pin edge (3 at default).
- MISO:
  - MSB valid SYNC_STAGES+1 clks after SS_n falls, before the first SCLK rise the master samples.
  - Each later bit changes SYNC_STAGES+1 clks after its SCLK fall, i.e. well before the next rise.
- cmd_rdy asserts SYNC_STAGES+1 clks after SS_n rises; last_chnl updates in the same clk.
- Back-to-back transactions need SS_n high for at least SYNC_STAGES+2 clks.
- The first transaction after reset returns channel 0. A two-transaction read (command, then read) returns the commanded channel on the second.

## Configuration
- A2D_RESP_CHK_EN defined:
  - err sets at SS_n rise when bit_cnt != 16, or when bit_cnt == 16 and rx_shft[15:14] != 0 or rx_shft[10:0] != 0.
  - err stays set until rst_n.
  - A 16-bit command with nonzero reserved bits still updates last_chnl.
- A2D_RESP_CHK_EN undefined: err is constant 0 and no checker logic is built. All other behaviour is identical.

## Test plan
- Reset, then a transaction with cmd 16'h1800 and ch_data channel 0 = 12'hABC -> MISO returns 16'h0ABC, cmd_rdy pulses once, last_chnl = 3.
- Second transaction with cmd 16'h0000 and channel 3 = 12'h5A5 -> MISO returns 16'h05A5, last_chnl = 0.
- ch_data channel 3 changes from 12'h123 to 12'hFFF mid-transaction -> returned value stays 16'h0123.
- SS_n raised after 9 SCLK rises -> no cmd_rdy, last_chnl unchanged; err = 1 with A2D_RESP_CHK_EN, 0 without.
- cmd 16'hC800 (reserved bits set) -> last_chnl = 1, cmd_rdy pulses; err = 1 only with A2D_RESP_CHK_EN.
- rst_n asserted after 8 bits of cmd 16'h3800 -> MISO 0, last_chnl 0; next full transaction returns channel 0 data and behaves normally.
